second_layer_tnndirect: RTL and testbench

Output stage of the ternary direct-mapped classifier. It sits directly downstream of the first (hidden) layer and starts when that layer raises `done`. It then scores every class against the binary hidden vector using hard-wired ternary weights, one hidden neuron per cycle, and selects the winning class with a sequential argmax. The result is a registered class index plus a sticky `done`.

---
 rtl/second_layer_tnndirect_pkg.sv | 24 ++
 rtl/second_layer_tnndirect_if.sv | 22 ++
 rtl/second_layer_tnndirect_argmax.sv | 59 +++++
 rtl/second_layer_tnndirect.sv | 156 +++++++++++++++
 tb/tb_second_layer_tnndirect.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/second_layer_tnndirect_pkg.sv
// Shared definitions for the ternary direct-mapped classifier layers.
// Provides the layer FSM state encoding and width helpers for scores and
// indices, reused by the hidden layer, this output layer and the top level.
package second_layer_tnndirect_pkg;

  // Common sequencing states of a single-shot tnndirect layer.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_ARGMAX = 2'd2,
    ST_DONE   = 2'd3
  } tnn_state_e;

  // Signed width that holds every score in [-hidden_cnt, +hidden_cnt].
  function automatic int unsigned score_width(input int unsigned hidden_cnt);
    return $clog2(hidden_cnt + 1) + 1;
  endfunction

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/second_layer_tnndirect_if.sv
// Handshake bundle between the hidden layer/consumer and the output layer.
//   start     : level request (hidden layer's done)
//   hidden    : binary hidden activations, bit j = neuron j
//   class_out : registered winning class index
//   done      : sticky result-valid flag
// master = upstream/consumer side, slave = second_layer_tnndirect.
interface second_layer_tnndirect_if
  import second_layer_tnndirect_pkg::*;
#(
  parameter int unsigned HIDDEN_CNT = 4,
  parameter int unsigned CLASS_CNT  = 3
);
  localparam int unsigned CIDX_W = idx_width(CLASS_CNT);

  logic                  start;
  logic [HIDDEN_CNT-1:0] hidden;
  logic [CIDX_W-1:0]     class_out;
  logic                  done;

  modport master (output start, hidden, input class_out, done);
  modport slave  (input start, hidden, output class_out, done);
endinterface

// File: rtl/second_layer_tnndirect_argmax.sv
// Serial compare/track-best unit: one score per valid cycle, strict greater
// comparison so ties keep the lowest index.
//   clk, rst   : clock, async active-high reset
//   valid      : score/idx present this cycle
//   first      : restart tracking with this score (idx 0 of a sweep)
//   idx        : index of the presented score
//   score      : signed score
//   best_idx_c : best index including the current compare (combinational)
module argmax_seq_tnndirect
  import second_layer_tnndirect_pkg::*;
#(
  parameter int unsigned CNT = 3,
  parameter int unsigned W   = 4,
  localparam int unsigned IDX_W = idx_width(CNT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic                first,
  input  logic [IDX_W-1:0]    idx,
  input  logic signed [W-1:0] score,
  output logic [IDX_W-1:0]    best_idx_c
);

  // Most-negative representable value: any real score beats it.
  localparam logic signed [W-1:0] SCORE_MIN = {1'b1, {(W-1){1'b0}}};

  logic signed [W-1:0] best_q, best_d;
  logic [IDX_W-1:0]    best_idx_q, best_idx_d;

  // Running best, restarted on first so idx 0 is always taken.
  always_comb begin
    best_d     = best_q;
    best_idx_d = best_idx_q;
    if (valid) begin
      if (first) begin
        best_d     = SCORE_MIN;
        best_idx_d = '0;
      end
      if (score > best_d) begin
        best_d     = score;
        best_idx_d = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_q     <= SCORE_MIN;
      best_idx_q <= '0;
    end else begin
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
    end
  end

  assign best_idx_c = best_idx_d;

endmodule

// File: rtl/second_layer_tnndirect.sv
// Output stage of the ternary direct-mapped classifier. On start it latches
// the hidden vector, accumulates all class scores in parallel one hidden
// neuron per cycle using constant ternary weights, then runs a sequential
// argmax and holds the winning class with a sticky done until rst.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of second_layer_tnndirect_if (start, hidden in;
//              class_out, done out, both registered)
module second_layer_tnndirect
  import second_layer_tnndirect_pkg::*;
#(
  parameter int unsigned HIDDEN_CNT = 4,
  parameter int unsigned CLASS_CNT  = 3,
  parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] SPARSE_VALS = '0,
  parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] MASK        = '0
) (
  input logic clk,
  input logic rst,
  second_layer_tnndirect_if.slave bus
);

  localparam int unsigned SW      = score_width(HIDDEN_CNT);
  localparam int unsigned CIDX_W  = idx_width(CLASS_CNT);
  localparam int unsigned CNT_MAX = (HIDDEN_CNT > CLASS_CNT) ? HIDDEN_CNT : CLASS_CNT;
  localparam int unsigned CNT_W   = idx_width(CNT_MAX);

  tnn_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [HIDDEN_CNT-1:0] hid_q;
  logic [CIDX_W-1:0]     class_out_q, class_out_d;
  logic                  done_q, done_d;
  logic                  latch_c, acc_c, arg_valid_c, arg_first_c;
  logic                  hid_bit_c;
  logic signed [SW-1:0]  score_q [CLASS_CNT];
  logic signed [SW-1:0]  score_sel_c;
  logic [CIDX_W-1:0]     best_idx_c;

  // Sequencer next-state and control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    class_out_d = class_out_q;
    done_d      = done_q;
    latch_c     = 1'b0;
    acc_c       = 1'b0;
    arg_valid_c = 1'b0;
    arg_first_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          latch_c = 1'b1;
          cnt_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        acc_c = 1'b1;
        if (cnt_q == CNT_W'(HIDDEN_CNT - 1)) begin
          cnt_d   = '0;
          state_d = ST_ARGMAX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ARGMAX: begin
        arg_valid_c = 1'b1;
        arg_first_c = (cnt_q == '0);
        if (cnt_q == CNT_W'(CLASS_CNT - 1)) begin
          class_out_d = best_idx_c;
          done_d      = 1'b1;
          cnt_d       = '0;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      class_out_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      class_out_q <= class_out_d;
      done_q      <= done_d;
    end
  end

  // Hidden vector captured once per sample; later changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          hid_q <= '0;
    else if (latch_c) hid_q <= bus.hidden;
  end

  // Hidden bit for the neuron currently being accumulated.
  always_comb begin
    hid_bit_c = 1'b0;
    for (int j = 0; j < HIDDEN_CNT; j++)
      if (cnt_q == CNT_W'(j)) hid_bit_c = hid_q[j];
  end

  // Per-class accumulators; weights select from constants, nothing stored.
  for (genvar c = 0; c < CLASS_CNT; c++) begin : g_cls
    logic m_c, s_c;

    always_comb begin
      m_c = 1'b0;
      s_c = 1'b0;
      for (int j = 0; j < HIDDEN_CNT; j++) begin
        if (cnt_q == CNT_W'(j)) begin
          m_c = MASK[c*HIDDEN_CNT + j];
          s_c = SPARSE_VALS[c*HIDDEN_CNT + j];
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)               score_q[c] <= '0;
      else if (latch_c)      score_q[c] <= '0;
      else if (acc_c && m_c) score_q[c] <= (s_c == hid_bit_c) ? score_q[c] + SW'(1)
                                                              : score_q[c] - SW'(1);
    end
  end

  // Score of the class currently presented to the argmax.
  always_comb begin
    score_sel_c = '0;
    for (int c = 0; c < CLASS_CNT; c++)
      if (cnt_q == CNT_W'(c)) score_sel_c = score_q[c];
  end

  argmax_seq_tnndirect #(
    .CNT (CLASS_CNT),
    .W   (SW)
  ) u_argmax (
    .clk        (clk),
    .rst        (rst),
    .valid      (arg_valid_c),
    .first      (arg_first_c),
    .idx        (CIDX_W'(cnt_q)),
    .score      (score_sel_c),
    .best_idx_c (best_idx_c)
  );

  assign bus.class_out = class_out_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_second_layer_tnndirect.sv
// Directed bench for second_layer_tnndirect (H=4, C=3).
// dut_a: all weights active, signs class0=1111, class1=0000, class2=1010.
// dut_b: same signs, all weights masked (every score stays 0).
module tb_second_layer_tnndirect;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  second_layer_tnndirect_if #(.HIDDEN_CNT(4), .CLASS_CNT(3)) ifa ();
  second_layer_tnndirect_if #(.HIDDEN_CNT(4), .CLASS_CNT(3)) ifb ();

  second_layer_tnndirect #(
    .HIDDEN_CNT  (4),
    .CLASS_CNT   (3),
    .SPARSE_VALS (12'b1010_0000_1111),
    .MASK        (12'hFFF)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  second_layer_tnndirect #(
    .HIDDEN_CNT  (4),
    .CLASS_CNT   (3),
    .SPARSE_VALS (12'b1010_0000_1111),
    .MASK        (12'h000)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifa.start = 1'b0; ifa.hidden = 4'b0000;
    ifb.start = 1'b0; ifb.hidden = 4'b0000;
    #2;
    tests++;
    if (ifa.done !== 1'b0 || ifa.class_out !== 2'd0) begin
      fails++;
      $display("FAIL reset_a: done=%b class_out=%0d, want done=0 class_out=0", ifa.done, ifa.class_out);
    end
    tests++;
    if (ifb.done !== 1'b0 || ifb.class_out !== 2'd0) begin
      fails++;
      $display("FAIL reset_b: done=%b class_out=%0d, want done=0 class_out=0", ifb.done, ifb.class_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One start pulse; done must rise exactly on edge 8 with the expected class.
  task automatic test_classify(input string name, input logic [3:0] hid, input logic [1:0] exp);
    apply_reset();
    ifa.hidden = hid;
    ifa.start  = 1'b1;
    tick();
    ifa.start  = 1'b0;
    ifa.hidden = ~hid;
    for (int e = 1; e <= 7; e++) begin
      tests++;
      if (ifa.done !== 1'b0 || ifa.class_out !== 2'd0) begin
        fails++;
        $display("FAIL %s_early_e%0d: done=%b class_out=%0d, want done=0 class_out=0",
                 name, e, ifa.done, ifa.class_out);
      end
      tick();
    end
    tests++;
    if (ifa.done !== 1'b1 || ifa.class_out !== exp) begin
      fails++;
      $display("FAIL %s_result: done=%b class_out=%0d, want done=1 class_out=%0d",
               name, ifa.done, ifa.class_out, exp);
    end
  endtask

  task automatic test_mask_zero();
    apply_reset();
    ifb.hidden = 4'b1111;
    ifb.start  = 1'b1;
    tick();
    ifb.start  = 1'b0;
    repeat (6) tick();
    tests++;
    if (ifb.done !== 1'b0) begin
      fails++;
      $display("FAIL mask0_edge7: done=%b, want 0", ifb.done);
    end
    tick();
    tests++;
    if (ifb.done !== 1'b1 || ifb.class_out !== 2'd0) begin
      fails++;
      $display("FAIL mask0_tie: done=%b class_out=%0d, want done=1 class_out=0", ifb.done, ifb.class_out);
    end
  endtask

  task automatic test_rst_mid_accum();
    // Reset from DONE must clear a non-zero result immediately, without a clock.
    test_classify("pre_rst", 4'b1010, 2'd2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (ifa.done !== 1'b0 || ifa.class_out !== 2'd0) begin
      fails++;
      $display("FAIL rst_async_done: done=%b class_out=%0d, want done=0 class_out=0", ifa.done, ifa.class_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // Start a run and reset it at edge 3 (inside ACCUM).
    ifa.hidden = 4'b1111;
    ifa.start  = 1'b1;
    tick();
    ifa.start  = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    tests++;
    if (ifa.done !== 1'b0 || ifa.class_out !== 2'd0) begin
      fails++;
      $display("FAIL rst_accum: done=%b class_out=%0d, want done=0 class_out=0", ifa.done, ifa.class_out);
    end
    @(negedge clk);
    rst = 1'b0;
    // Without a new start nothing may complete.
    repeat (10) tick();
    tests++;
    if (ifa.done !== 1'b0) begin
      fails++;
      $display("FAIL rst_idle_hold: done=%b, want 0", ifa.done);
    end
    @(negedge clk);
    ifa.hidden = 4'b0000;
    ifa.start  = 1'b1;
    tick();
    ifa.start  = 1'b0;
    repeat (7) tick();
    tests++;
    if (ifa.done !== 1'b1 || ifa.class_out !== 2'd1) begin
      fails++;
      $display("FAIL rst_restart: done=%b class_out=%0d, want done=1 class_out=1", ifa.done, ifa.class_out);
    end
  endtask

  task automatic test_hold_after_done();
    test_classify("pre_hold", 4'b0000, 2'd1);
    for (int e = 0; e < 6; e++) begin
      ifa.start  = ~ifa.start;
      ifa.hidden = 4'(e * 5 + 3);
      tick();
      tests++;
      if (ifa.done !== 1'b1 || ifa.class_out !== 2'd1) begin
        fails++;
        $display("FAIL hold_e%0d: done=%b class_out=%0d, want done=1 class_out=1", e, ifa.done, ifa.class_out);
      end
    end
    ifa.start = 1'b0;
  endtask

  // start held high across reset release: sampled on the first edge after it.
  task automatic test_start_held_through_reset();
    rst = 1'b1;
    ifa.hidden = 4'b1111;
    ifa.start  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (7) tick();
    tests++;
    if (ifa.done !== 1'b0) begin
      fails++;
      $display("FAIL held_start_edge7: done=%b, want 0", ifa.done);
    end
    tick();
    tests++;
    if (ifa.done !== 1'b1 || ifa.class_out !== 2'd0) begin
      fails++;
      $display("FAIL held_start_result: done=%b class_out=%0d, want done=1 class_out=0", ifa.done, ifa.class_out);
    end
    repeat (3) tick();
    tests++;
    if (ifa.done !== 1'b1 || ifa.class_out !== 2'd0) begin
      fails++;
      $display("FAIL held_start_sticky: done=%b class_out=%0d, want done=1 class_out=0", ifa.done, ifa.class_out);
    end
    ifa.start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_classify("h1111", 4'b1111, 2'd0);
    test_classify("h0000", 4'b0000, 2'd1);
    test_classify("h1010", 4'b1010, 2'd2);
    test_mask_zero();
    test_rst_mid_accum();
    test_hold_after_done();
    test_start_held_through_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
